// File: rtl/fifo_burst_reader.sv
// Drains an upstream FIFO in fixed-length TLAST-framed bursts, or in one partial
// burst on flush, through a 2-entry output buffer that absorbs downstream backpressure.
module fifo_burst_reader #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 14,
    parameter int BURST   = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [COUNT_W-1:0] fifo_count,
    input  logic               flush,
    input  logic [WIDTH-1:0]   in0_V_V_TDATA,
    input  logic               in0_V_V_TVALID,
    output logic               in0_V_V_TREADY,
    output logic [WIDTH-1:0]   out_V_V_TDATA,
    output logic               out_V_V_TVALID,
    input  logic               out_V_V_TREADY,
    output logic               out_V_V_TLAST,
    output logic [15:0]        burst_cnt,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_FLUSH
    } state_t;

    localparam logic [COUNT_W-1:0] BURST_LEN = COUNT_W'(BURST);
    localparam logic [COUNT_W-1:0] ONE       = COUNT_W'(1);

    state_t             state, state_nxt;
    logic [COUNT_W-1:0] remaining, remaining_nxt;

    logic [WIDTH-1:0]   buf_data [2];
    logic               buf_last [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         occ;

    logic               push, pop, push_last;

    // Ready depends only on registered state and occupancy, never on out TREADY.
    assign in0_V_V_TREADY = (state != ST_IDLE) && (occ != 2'd2);
    assign push           = in0_V_V_TVALID && in0_V_V_TREADY;
    assign pop            = out_V_V_TVALID && out_V_V_TREADY;
    assign push_last      = (remaining == ONE);

    assign out_V_V_TVALID = (occ != 2'd0);
    assign out_V_V_TDATA  = buf_data[rd_ptr];
    assign out_V_V_TLAST  = buf_last[rd_ptr];
    assign busy           = (state != ST_IDLE) || (occ != 2'd0);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_nxt     = state;
        remaining_nxt = remaining;
        unique case (state)
            ST_IDLE: begin
                if (fifo_count >= BURST_LEN) begin
                    state_nxt     = ST_BURST;
                    remaining_nxt = BURST_LEN;
                end else if (flush && (fifo_count != '0)) begin
                    state_nxt     = ST_FLUSH;
                    remaining_nxt = fifo_count;
                end
            end
            ST_BURST, ST_FLUSH: begin
                if (push) begin
                    remaining_nxt = remaining - ONE;
                    if (push_last) state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                remaining_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // NOTE: the buffer is only two entries, so it is reset to give clean zero outputs.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= in0_V_V_TDATA;
                buf_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)                 burst_cnt <= '0;
        else if (pop && out_V_V_TLAST) burst_cnt <= burst_cnt + 16'd1;
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a modelled upstream FIFO feeds counting data,
// a monitor records handshakes, and each scenario task checks its own results.
module tb_fifo_burst_reader;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 14;
    localparam int BURST   = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               valid_en = 1'b0;
    logic               out_ready = 1'b1;
    logic [COUNT_W-1:0] fifo_count;
    logic [WIDTH-1:0]   in0_tdata, out_tdata;
    logic               in0_tvalid, in0_tready, out_tvalid, out_tlast, busy;
    logic [15:0]        burst_cnt;

    int total = 0;
    int bad   = 0;

    // Upstream FIFO model: fill_total written by tasks, consumed only by the monitor.
    int fill_total = 0;
    int consumed   = 0;
    assign fifo_count = COUNT_W'(fill_total - consumed);
    assign in0_tdata  = WIDTH'(consumed + 1);
    assign in0_tvalid = valid_en && (fifo_count != '0);

    always #5 clk = ~clk;

    fifo_burst_reader #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .BURST(BURST)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .fifo_count(fifo_count), .flush(flush),
        .in0_V_V_TDATA(in0_tdata), .in0_V_V_TVALID(in0_tvalid), .in0_V_V_TREADY(in0_tready),
        .out_V_V_TDATA(out_tdata), .out_V_V_TVALID(out_tvalid), .out_V_V_TREADY(out_ready),
        .out_V_V_TLAST(out_tlast), .burst_cnt(burst_cnt), .busy(busy)
    );

    int         cyc = 0;
    int         cap_n = 0;
    logic [7:0] cap_data [512];
    logic       cap_last [512];
    int         hs_cyc   [512];
    int         out_cyc  [512];
    int         stall_err = 0;
    int         occ_m = 0;
    int         max_occ = 0;
    logic       stalled_q = 1'b0;
    logic [7:0] held_data = '0;
    logic       held_last = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in0_tvalid && in0_tready) begin
            hs_cyc[consumed] <= cyc;
            consumed         <= consumed + 1;
        end
        if (out_tvalid && out_ready) begin
            cap_data[cap_n] <= out_tdata;
            cap_last[cap_n] <= out_tlast;
            out_cyc[cap_n]  <= cyc;
            cap_n           <= cap_n + 1;
        end
        if (rst_n && stalled_q && (!out_tvalid || out_tdata !== held_data || out_tlast !== held_last))
            stall_err <= stall_err + 1;
        stalled_q <= rst_n && out_tvalid && !out_ready;
        held_data <= out_tdata;
        held_last <= out_tlast;
        if (!rst_n) occ_m <= 0;
        else occ_m <= occ_m + int'(in0_tvalid && in0_tready) - int'(out_tvalid && out_ready);
        if (occ_m > max_occ) max_occ <= occ_m;
    end

    // Drives the stream until cap_target words are out and the block is idle.
    task automatic run_until(input int cap_target, input bit toggle_ready,
                             input logic [15:0] vpat, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (cap_n >= cap_target && !busy) begin
                ok = 1'b1;
                break;
            end
            out_ready = toggle_ready ? ~out_ready : 1'b1;
            valid_en  = vpat[k % 16];
        end
        out_ready = 1'b1;
        valid_en  = 1'b1;
    endtask

    // Checks n captured words starting at s carry data c+1.. with TLAST at each multiple of BURST or the end.
    task automatic check_words(input string name, input int s, input int c, input int n, input int blen);
        logic [7:0] exp_d;
        logic       exp_l;
        for (int i = 0; i < n; i++) begin
            exp_d = 8'(c + i + 1);
            exp_l = ((i + 1) % blen == 0) || (i == n - 1);
            total++;
            if (cap_data[s+i] !== exp_d) begin bad++; $display("FAIL %s_data[%0d] got=%0d want=%0d", name, i, cap_data[s+i], exp_d); end
            total++;
            if (cap_last[s+i] !== exp_l) begin bad++; $display("FAIL %s_last[%0d] got=%0b want=%0b", name, i, cap_last[s+i], exp_l); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (in0_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%0b want=0", in0_tready); end
        total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%0b want=0", out_tvalid); end
        total++; if (out_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%0b want=0", out_tlast); end
        total++; if (out_tdata !== 8'd0) begin bad++; $display("FAIL reset_tdata got=%0d want=0", out_tdata); end
        total++; if (burst_cnt !== 16'd0) begin bad++; $display("FAIL reset_burst_cnt got=%0d want=0", burst_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        int s = cap_n;
        int c = consumed;
        bit ok;
        fill_total = c + 20;
        valid_en   = 1'b1;
        out_ready  = 1'b1;
        total++; if (in0_tready !== 1'b0) begin bad++; $display("FAIL single_tready_early got=%0b want=0", in0_tready); end
        @(negedge clk);
        total++; if (in0_tready !== 1'b1) begin bad++; $display("FAIL single_tready_first got=%0b want=1", in0_tready); end
        run_until(s + 16, 1'b0, 16'hFFFF, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d words want=16", cap_n - s); end
        repeat (3) @(negedge clk);
        check_words("single", s, c, 16, 16);
        total++; if (out_cyc[s] - hs_cyc[c] !== 1) begin bad++; $display("FAIL single_latency got=%0d want=1", out_cyc[s] - hs_cyc[c]); end
        total++; if (consumed - c !== 16) begin bad++; $display("FAIL single_reads got=%0d want=16", consumed - c); end
        total++; if (fifo_count !== 14'd4) begin bad++; $display("FAIL single_left got=%0d want=4", fifo_count); end
        total++; if (burst_cnt !== 16'd1) begin bad++; $display("FAIL single_burst_cnt got=%0d want=1", burst_cnt); end
        total++; if (in0_tready !== 1'b0) begin bad++; $display("FAIL single_idle_tready got=%0b want=0", in0_tready); end
    endtask

    task automatic test_flush();
        int s = cap_n;
        int c = consumed;
        bit ok;
        bit saw_ready = 1'b0;
        bit saw_busy  = 1'b0;
        fill_total = c + 5;
        flush      = 1'b1;
        run_until(s + 5, 1'b0, 16'hFFFF, ok);
        flush = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL flush_timeout got=%0d words want=5", cap_n - s); end
        check_words("flush", s, c, 5, 5);
        total++; if (burst_cnt !== 16'd2) begin bad++; $display("FAIL flush_burst_cnt got=%0d want=2", burst_cnt); end
        // Empty FIFO: flush must not start anything.
        c     = consumed;
        flush = 1'b1;
        repeat (6) begin
            @(negedge clk);
            saw_ready |= in0_tready;
            saw_busy  |= busy;
        end
        flush = 1'b0;
        total++; if (saw_ready !== 1'b0) begin bad++; $display("FAIL flush0_tready got=%0b want=0", saw_ready); end
        total++; if (saw_busy !== 1'b0) begin bad++; $display("FAIL flush0_busy got=%0b want=0", saw_busy); end
        total++; if (consumed - c !== 0) begin bad++; $display("FAIL flush0_reads got=%0d want=0", consumed - c); end
    endtask

    task automatic test_backpressure();
        int s = cap_n;
        int c = consumed;
        bit ok;
        fill_total = c + 16;
        run_until(s + 16, 1'b1, 16'b1101_1011_0111_0110, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=%0d words want=16", cap_n - s); end
        check_words("bp", s, c, 16, 16);
        total++; if (consumed - c !== 16) begin bad++; $display("FAIL bp_reads got=%0d want=16", consumed - c); end
        total++; if (max_occ > 2) begin bad++; $display("FAIL bp_max_occ got=%0d want<=2", max_occ); end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d changes want=0", stall_err); end
        total++; if (burst_cnt !== 16'd3) begin bad++; $display("FAIL bp_burst_cnt got=%0d want=3", burst_cnt); end
    endtask

    task automatic test_back_to_back();
        int s = cap_n;
        int c = consumed;
        bit ok;
        fill_total = c + 40;
        run_until(s + 32, 1'b0, 16'hFFFF, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d words want=32", cap_n - s); end
        repeat (3) @(negedge clk);
        check_words("b2b", s, c, 32, 16);
        total++; if (hs_cyc[c+16] - hs_cyc[c+15] !== 2) begin bad++; $display("FAIL b2b_gap got=%0d want=2", hs_cyc[c+16] - hs_cyc[c+15]); end
        total++; if (hs_cyc[c+15] - hs_cyc[c] !== 15) begin bad++; $display("FAIL b2b_rate got=%0d want=15", hs_cyc[c+15] - hs_cyc[c]); end
        total++; if (fifo_count !== 14'd8) begin bad++; $display("FAIL b2b_left got=%0d want=8", fifo_count); end
        total++; if (burst_cnt !== 16'd5) begin bad++; $display("FAIL b2b_burst_cnt got=%0d want=5", burst_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        int s = cap_n;
        int c = consumed;
        bit ok = 1'b0;
        bit aborted_last = 1'b0;
        fill_total = c - 8 + 8 + 16 + (fill_total - c);
        fill_total = c + 16;
        valid_en   = 1'b1;
        out_ready  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (consumed - c >= 7) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=%0d reads want=7", consumed - c); end
        rst_n    = 1'b0;
        valid_en = 1'b0;
        @(negedge clk);
        total++; if (in0_tready !== 1'b0) begin bad++; $display("FAIL rstmid_tready got=%0b want=0", in0_tready); end
        total++; if (out_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%0b want=0", out_tvalid); end
        total++; if ({out_tdata, out_tlast} !== 9'd0) begin bad++; $display("FAIL rstmid_data got=%0h want=0", {out_tdata, out_tlast}); end
        total++; if (burst_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_burst_cnt got=%0d want=0", burst_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
        for (int i = s; i < cap_n; i++) aborted_last |= cap_last[i];
        total++; if (aborted_last !== 1'b0) begin bad++; $display("FAIL rstmid_no_tlast got=%0b want=0", aborted_last); end
        rst_n = 1'b1;
        s = cap_n;
        c = consumed;
        fill_total = c + 16;
        run_until(s + 16, 1'b0, 16'hFFFF, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_fresh_timeout got=%0d words want=16", cap_n - s); end
        check_words("rstmid", s, c, 16, 16);
        total++; if (burst_cnt !== 16'd1) begin bad++; $display("FAIL rstmid_fresh_cnt got=%0d want=1", burst_cnt); end
    endtask

    task automatic test_burst_cnt_wrap();
        int s;
        int c;
        bit ok;
        @(negedge clk);
        force dut.burst_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.burst_cnt;
        @(negedge clk);
        total++; if (burst_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preset got=%0h want=ffff", burst_cnt); end
        s = cap_n;
        c = consumed;
        fill_total = c + 2;
        flush      = 1'b1;
        run_until(s + 2, 1'b0, 16'hFFFF, ok);
        flush = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout got=%0d words want=2", cap_n - s); end
        check_words("wrap", s, c, 2, 2);
        total++; if (burst_cnt !== 16'd0) begin bad++; $display("FAIL wrap_burst_cnt got=%0h want=0", burst_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        test_burst_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
